// File: rtl/z80_pkg.sv
// Shared Z80 bus types: machine-cycle opcodes, T-state encoding
// and the registered strobe bundle driven onto the external bus.
package z80_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        MEM_RD = 2'b01,
        MEM_WR = 2'b10,
        RSVD   = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } bus_state_t;

    typedef struct packed {
        logic m1_l;
        logic mreq_l;
        logic rd_l;
        logic wr_l;
        logic rfsh_l;
        logic oe;
        logic done;
        logic ready;
    } bus_out_t;

    localparam bus_out_t OUT_IDLE = '{
        m1_l:   1'b1,
        mreq_l: 1'b1,
        rd_l:   1'b1,
        wr_l:   1'b1,
        rfsh_l: 1'b1,
        oe:     1'b0,
        done:   1'b0,
        ready:  1'b1
    };

endpackage

// File: rtl/z80_bus_ctrl.sv
// Z80 bus interface unit: turns single core requests into
// T-state-accurate M1 / memory read / memory write cycles.
module z80_bus_ctrl
    import z80_pkg::*;
(
    input  logic        clk,
    input  logic        rst_L,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [15:0] ir_addr,
    output logic        req_ready,
    output logic        done,
    output logic [7:0]  rdata,
    input  logic        WAIT_L,
    output logic        M1_L,
    output logic        MREQ_L,
    output logic        RD_L,
    output logic        WR_L,
    output logic        RFSH_L,
    inout  wire  [15:0] addr_bus,
    inout  wire  [7:0]  data_bus
);

    bus_state_t  r_state;
    bus_state_t  w_next;
    bus_op_t     r_op;
    bus_op_t     w_op;
    bus_out_t    r_out;
    bus_out_t    w_out;
    logic [15:0] r_addr;
    logic [15:0] r_abus;
    logic [15:0] w_abus;
    logic [15:0] w_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        w_acc;
    logic        w_cap;

    assign w_acc = req_valid && (r_state == IDLE)
                && (req_op != RSVD);
    assign w_op   = (r_state == IDLE) ? bus_op_t'(req_op) : r_op;
    assign w_addr = (r_state == IDLE) ? req_addr : r_addr;
    assign w_cap  = ((r_state == T2) || (r_state == TW))
                 && WAIT_L && (r_op != MEM_WR);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= IDLE;
            r_out   <= OUT_IDLE;
            r_abus  <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
            r_abus  <= w_abus;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_op    <= FETCH;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_acc) begin
                r_op    <= bus_op_t'(req_op);
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_cap) begin
                r_rdata <= data_bus;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_acc ? T1 : IDLE;
            T1:      w_next = T2;
            T2, TW:  w_next = WAIT_L ? T3 : TW;
            T3:      w_next = (r_op == FETCH) ? T4 : IDLE;
            T4:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register
    // in step with the state they belong to.
    always_comb begin
        w_out  = OUT_IDLE;
        w_abus = r_abus;
        w_out.ready = (w_next == IDLE);
        unique case (w_next)
            T1, T2, TW: begin
                w_abus       = w_addr;
                w_out.mreq_l = 1'b0;
                w_out.m1_l   = (w_op != FETCH);
                w_out.rd_l   = (w_op == MEM_WR);
                w_out.oe     = (w_op == MEM_WR);
                w_out.wr_l   = !((w_op == MEM_WR)
                             && (w_next != T1));
            end
            T3: begin
                if (w_op == FETCH) begin
                    w_abus       = ir_addr;
                    w_out.mreq_l = 1'b0;
                    w_out.rfsh_l = 1'b0;
                end else begin
                    w_out.done = 1'b1;
                    w_out.oe   = (w_op == MEM_WR);
                end
            end
            T4: begin
                w_abus       = ir_addr;
                w_out.rfsh_l = 1'b0;
                w_out.done   = 1'b1;
            end
            default: begin
                w_out.ready = 1'b1;
            end
        endcase
    end

    assign req_ready = r_out.ready;
    assign done      = r_out.done;
    assign rdata     = r_rdata;
    assign M1_L      = r_out.m1_l;
    assign MREQ_L    = r_out.mreq_l;
    assign RD_L      = r_out.rd_l;
    assign WR_L      = r_out.wr_l;
    assign RFSH_L    = r_out.rfsh_l;
    assign addr_bus  = r_abus;
    assign data_bus  = r_out.oe ? r_wdata : 8'hzz;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: cycle-indexed reference model of each
// machine cycle plus a byte memory on the external bus.
module tb_z80_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [15:0] ir_addr;
    logic        req_ready;
    logic        done;
    logic [7:0]  rdata;
    logic        WAIT_L;
    logic        M1_L, MREQ_L, RD_L, WR_L, RFSH_L;
    wire  [15:0] addr_bus;
    wire  [7:0]  data_bus;

    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    logic [7:0]  exp_rdata;
    logic [15:0] exp_abus;
    logic [7:0]  zz = 8'hzz;
    int          n_chk = 0;
    int          n_err = 0;

    z80_bus_ctrl dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ir_addr   (ir_addr),
        .req_ready (req_ready),
        .done      (done),
        .rdata     (rdata),
        .WAIT_L    (WAIT_L),
        .M1_L      (M1_L),
        .MREQ_L    (MREQ_L),
        .RD_L      (RD_L),
        .WR_L      (WR_L),
        .RFSH_L    (RFSH_L),
        .addr_bus  (addr_bus),
        .data_bus  (data_bus)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, clocked-write byte memory
    assign data_bus = (!MREQ_L && !RD_L) ? mem[addr_bus[7:0]] : 8'hzz;
    always @(posedge clk)
        if (!MREQ_L && !WR_L) mem[addr_bus[7:0]] <= data_bus;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " strobes"}, {M1_L, MREQ_L, RD_L, WR_L, RFSH_L}, 5'h1f);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " ready"}, req_ready, 1'b1);
        chk({tag, " addr"}, addr_bus, exp_abus);
        chk({tag, " rdata"}, rdata, exp_rdata);
        chk({tag, " data_z"}, data_bus, zz);
    endtask

    // Starts and ends on a falling edge with the controller idle
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a,
                           input logic [7:0] wd, input int nw,
                           input logic [15:0] ir);
        int          len;
        int          acc_end;
        logic [7:0]  rv;
        logic        acc;
        logic [4:0]  e_strb;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        len     = ((op == 2'd0) ? 4 : 3) + nw;
        acc_end = 2 + nw;
        rv      = ref_mem[a[7:0]];
        chk("ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        ir_addr   = ir;
        WAIT_L    = 1'($urandom);
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k < len) begin
                req_valid = 1'($urandom);
                req_op    = 2'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            if (k >= 2 && k < acc_end) WAIT_L = 1'b0;
            else if (k == acc_end)     WAIT_L = 1'b1;
            else                       WAIT_L = 1'($urandom);
            acc    = (k <= acc_end);
            e_strb = {!(op == 2'd0 && acc),
                      !(k < len),
                      !(op != 2'd2 && acc),
                      !(op == 2'd2 && acc && k >= 2),
                      !(op == 2'd0 && k > acc_end)};
            e_addr = (op == 2'd0 && k > acc_end) ? ir : a;
            if (op == 2'd2)      e_data = wd;
            else if (acc)        e_data = rv;
            else                 e_data = zz;
            chk($sformatf("strobes op%0d k%0d", op, k),
                {M1_L, MREQ_L, RD_L, WR_L, RFSH_L}, e_strb);
            chk($sformatf("addr op%0d k%0d", op, k), addr_bus, e_addr);
            chk($sformatf("data op%0d k%0d", op, k), data_bus, e_data);
            chk($sformatf("done op%0d k%0d", op, k), done, k == len);
            chk($sformatf("ready op%0d k%0d", op, k), req_ready, 1'b0);
            if (k == len)
                chk($sformatf("rdata op%0d", op), rdata,
                    (op != 2'd2) ? rv : exp_rdata);
        end
        if (op != 2'd2) exp_rdata = rv;
        else            ref_mem[a[7:0]] = wd;
        exp_abus = (op == 2'd0) ? ir : a;
        @(negedge clk);
        WAIT_L = 1'($urandom);
        chk_idle("idle_after");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[8'h00] = 8'h2A;  ref_mem[8'h00] = 8'h2A;
        mem[8'hBC] = 8'hBE;  ref_mem[8'hBC] = 8'hBE;
        mem[8'h40] = 8'h11;  ref_mem[8'h40] = 8'h11;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        ir_addr   = 16'h1234;
        WAIT_L    = 1'b1;
        exp_rdata = '0;
        exp_abus  = '0;
        rst_L     = 1'b1;
        #1 rst_L  = 1'b0;
        #1 chk_idle("reset");
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        run_txn(2'd0, 16'h0000, 8'h00, 0, 16'h1234);
        run_txn(2'd2, 16'h0005, 8'hCC, 0, 16'h1234);
        run_txn(2'd1, 16'h0005, 8'h00, 0, 16'h1234);
        run_txn(2'd1, 16'h00BC, 8'h00, 2, 16'h1234);

        // Reset lands in T2 of a write: no edge, no done, no write
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 16'h0040;
        req_wdata = 8'h99;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_wr_low", WR_L, 1'b0);
        #2 rst_L = 1'b0;
        #1;
        exp_rdata = '0;
        exp_abus  = '0;
        chk_idle("abort_async");
        @(negedge clk);
        chk_idle("abort_held");
        rst_L = 1'b1;
        @(negedge clk);
        chk_idle("abort_release");
        run_txn(2'd1, 16'h0040, 8'h00, 0, 16'h1234);

        req_valid = 1'b1;
        req_op    = 2'd3;
        req_addr  = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("rsvd%0d", i));
        end
        req_valid = 1'b0;

        run_txn(2'd0, 16'h00BC, 8'h00, 0, 16'h5678);
        run_txn(2'd1, 16'h0000, 8'h00, 1, 16'h5678);

        for (int n = 0; n < 40; n++) begin
            run_txn(2'($urandom_range(0, 2)),
                    16'($urandom_range(0, 255)),
                    8'($urandom), $urandom_range(0, 3),
                    16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
